// File: rtl/dmem_arbiter.sv
// Shares data_ram between the CPU port (priority) and an external port, with an anti-starvation counter.
// Latency: ack is high in the cycle after edge N+ACCESS_CYCLES when the request is accepted at edge N.
// Backpressure: requesters hold their level request until ack; inputs are sampled only while IDLE.
module dmem_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 10,
  parameter int DATA_BUS_WIDTH    = 64,
  parameter int ACCESS_CYCLES     = 2,
  parameter int STARVE_LIMIT      = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cpu_req,
  input  logic                         cpu_we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    cpu_wdata,
  output logic [DATA_BUS_WIDTH-1:0]    cpu_rdata,
  output logic                         cpu_ack,
  input  logic                         ext_req,
  input  logic                         ext_we,
  input  logic [ADDRESS_BUS_WIDTH-1:0] ext_addr,
  input  logic [DATA_BUS_WIDTH-1:0]    ext_wdata,
  output logic [DATA_BUS_WIDTH-1:0]    ext_rdata,
  output logic                         ext_ack,
  output logic                         mem_cs,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDRESS_BUS_WIDTH-1:0] mem_addr,
  output logic [DATA_BUS_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_BUS_WIDTH-1:0]    mem_rdata,
  output logic                         busy,
  output logic                         grant_ext
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  typedef struct packed {
    logic                         we;
    logic [ADDRESS_BUS_WIDTH-1:0] addr;
    logic [DATA_BUS_WIDTH-1:0]    wdata;
  } txn_t;

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic [3:0] starve_cnt;
  txn_t       txn;
  logic       owner_ext;
  logic       arb_go;
  logic       ext_win;
  logic       last_beat;

  always_comb begin
    arb_go    = (state == IDLE) && (cpu_req || ext_req);
    ext_win   = ext_req && (!cpu_req || (starve_cnt >= 4'(STARVE_LIMIT)));
    last_beat = (state == ACCESS) && (cnt == 4'(ACCESS_CYCLES - 1));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_go) state_nxt = ACCESS;
      ACCESS:  if (last_beat) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      starve_cnt <= '0;
      txn        <= '0;
      owner_ext  <= 1'b0;
      cpu_rdata  <= '0;
      ext_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_go) begin
            txn       <= ext_win ? {ext_we, ext_addr, ext_wdata} : {cpu_we, cpu_addr, cpu_wdata};
            owner_ext <= ext_win;
            cnt       <= '0;
          end
          // Only a lost arbitration with ext waiting ages the counter.
          if (!ext_req || ext_win)
            starve_cnt <= '0;
          else if (starve_cnt < 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
        end
        ACCESS: begin
          cnt <= last_beat ? 4'd0 : cnt + 4'd1;
          if (last_beat && !txn.we) begin
            if (owner_ext) ext_rdata <= mem_rdata;
            else           cpu_rdata <= mem_rdata;
          end
        end
        default: ;
      endcase
    end
  end

  // Strobes and acks decode straight from state so a reset drops them immediately.
  assign mem_cs    = (state == ACCESS);
  assign mem_read  = mem_cs && !txn.we;
  assign mem_write = mem_cs && txn.we;
  assign mem_addr  = mem_cs ? txn.addr  : '0;
  assign mem_wdata = mem_cs ? txn.wdata : '0;
  assign busy      = (state != IDLE);
  assign grant_ext = busy && owner_ext;
  assign cpu_ack   = (state == DONE) && !owner_ext;
  assign ext_ack   = (state == DONE) && owner_ext;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: each task drives one scenario and checks against hand-computed values.
module tb_dmem_arbiter;
  localparam int AW = 10;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          cpu_ack;
  logic          ext_req, ext_we;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata, ext_rdata;
  logic          ext_ack;
  logic          mem_cs, mem_read, mem_write;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          busy, grant_ext;

  logic [DW-1:0] mem_model [0:1023];
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = (mem_cs && mem_read) ? mem_model[mem_addr] : '0;

  dmem_arbiter #(.ADDRESS_BUS_WIDTH(AW), .DATA_BUS_WIDTH(DW), .ACCESS_CYCLES(2), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_rdata(ext_rdata), .ext_ack(ext_ack),
    .mem_cs(mem_cs), .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .grant_ext(grant_ext)
  );

  // Advance to just after the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 0; ext_we = 0; ext_addr = '0; ext_wdata = '0;
    for (int i = 0; i < 1024; i++) mem_model[i] = '0;
    tick(); tick();
    total++;
    if ({mem_cs, mem_read, mem_write, busy, grant_ext, cpu_ack, ext_ack} !== 7'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 0000000",
        {mem_cs, mem_read, mem_write, busy, grant_ext, cpu_ack, ext_ack});
    end
    total++;
    if (cpu_rdata !== '0 || ext_rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      bad++; $display("FAIL reset_bus: cpu_rdata=%h ext_rdata=%h mem_addr=%h mem_wdata=%h want 0",
        cpu_rdata, ext_rdata, mem_addr, mem_wdata);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_cpu_write();
    int wr_cycles = 0;
    int ack_cycle = -1;
    int ext_acks  = 0;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'd5; cpu_wdata = 64'hDEAD;
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (mem_write) begin
        wr_cycles++;
        total++;
        if (mem_addr !== 10'd5 || mem_wdata !== 64'hDEAD || !mem_cs || mem_read) begin
          bad++; $display("FAIL wr_bus: cycle %0d addr=%0d wdata=%h cs=%b rd=%b want 5/dead/1/0",
            c, mem_addr, mem_wdata, mem_cs, mem_read);
        end
      end
      if (ext_ack) ext_acks++;
      if (cpu_ack) begin
        if (ack_cycle < 0) ack_cycle = c; else ack_cycle = 99;
        total++;
        if (cpu_rdata !== '0) begin
          bad++; $display("FAIL wr_rdata: got %h want 0", cpu_rdata);
        end
        cpu_req = 0;
      end
    end
    total++;
    if (wr_cycles != 2) begin bad++; $display("FAIL wr_strobe_len: got %0d want 2", wr_cycles); end
    total++;
    if (ack_cycle != 3) begin bad++; $display("FAIL wr_ack_cycle: got %0d want 3", ack_cycle); end
    total++;
    if (ext_acks != 0) begin bad++; $display("FAIL wr_ext_ack: got %0d want 0", ext_acks); end
  endtask

  task automatic test_cpu_read();
    int rd_cycles = 0;
    int ack_cycle = -1;
    mem_model[5] = 64'hDEAD;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (mem_read) rd_cycles++;
      if (cpu_ack) begin
        ack_cycle = c;
        total++;
        if (cpu_rdata !== 64'hDEAD) begin
          bad++; $display("FAIL rd_data: got %h want dead", cpu_rdata);
        end
        cpu_req = 0;
      end
      total++;
      if (ext_rdata !== '0) begin bad++; $display("FAIL rd_ext_rdata: got %h want 0", ext_rdata); end
    end
    total++;
    if (rd_cycles != 2 || ack_cycle != 3) begin
      bad++; $display("FAIL rd_timing: strobes=%0d ack=%0d want 2/3", rd_cycles, ack_cycle);
    end
  endtask

  task automatic test_arbitration();
    logic order [10];
    int   n = 0;
    int   both = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd1;
    ext_req = 1; ext_we = 0; ext_addr = 10'd2;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick();
      if (cpu_ack && ext_ack) both++;
      if (cpu_ack || ext_ack) begin
        order[n] = ext_ack;
        n++;
        if (n == 10) begin cpu_req = 0; ext_req = 0; end
      end
    end
    total++;
    if (n != 10) begin bad++; $display("FAIL arb_timeout: got %0d acks want 10", n); end
    for (int i = 0; i < n; i++) begin
      total++;
      if (order[i] !== ((i == 4) || (i == 9))) begin
        bad++; $display("FAIL arb_order: grant %0d ext=%b want %b", i, order[i], (i == 4) || (i == 9));
      end
    end
    total++;
    if (both != 0) begin bad++; $display("FAIL arb_ack_excl: got %0d want 0", both); end
    tick();
  endtask

  task automatic test_ext_back_to_back();
    int acks [2];
    int n = 0;
    logic [DW-1:0] cpu_before;
    cpu_before = cpu_rdata;
    mem_model[300] = 64'h1234_5678_9ABC_DEF0;
    ext_req = 1; ext_we = 0; ext_addr = 10'd300;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (mem_cs) begin
        total++;
        if (!grant_ext || mem_addr !== 10'd300) begin
          bad++; $display("FAIL ext_grant: cycle %0d grant=%b addr=%0d want 1/300", c, grant_ext, mem_addr);
        end
      end
      if (ext_ack) begin
        if (n < 2) acks[n] = c;
        n++;
        total++;
        if (ext_rdata !== 64'h1234_5678_9ABC_DEF0) begin
          bad++; $display("FAIL ext_rdata: got %h want 123456789abcdef0", ext_rdata);
        end
        if (n == 2) ext_req = 0;
      end
    end
    total++;
    if (n != 2 || acks[0] != 3 || acks[1] != 7) begin
      bad++; $display("FAIL ext_b2b: acks=%0d at %0d,%0d want 2 at 3,7", n, acks[0], acks[1]);
    end
    total++;
    if (cpu_rdata !== cpu_before) begin
      bad++; $display("FAIL ext_cpu_rdata: got %h want %h", cpu_rdata, cpu_before);
    end
  endtask

  task automatic test_reset_abort();
    int acks = 0;
    int ack_cycle = -1;
    cpu_req = 1; cpu_we = 1; cpu_addr = 10'd20; cpu_wdata = 64'h55;
    tick(); tick();
    total++;
    if (!mem_write) begin bad++; $display("FAIL abort_pre: mem_write=%b want 1", mem_write); end
    reset = 1'b0;
    #1;
    total++;
    if ({mem_cs, mem_read, mem_write, busy} !== 4'b0) begin
      bad++; $display("FAIL abort_drop: cs/rd/wr/busy=%b want 0000", {mem_cs, mem_read, mem_write, busy});
    end
    cpu_req = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (cpu_ack || ext_ack) acks++;
    end
    reset = 1'b1;
    tick();
    total++;
    if (acks != 0 || cpu_ack || ext_ack) begin
      bad++; $display("FAIL abort_ack: got %0d acks want 0", acks);
    end
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5;
    for (int c = 1; c <= 5; c++) begin
      tick();
      if (cpu_ack) begin ack_cycle = c; cpu_req = 0; end
    end
    total++;
    if (ack_cycle != 3 || cpu_rdata !== 64'hDEAD) begin
      bad++; $display("FAIL abort_recover: ack=%0d rdata=%h want 3/dead", ack_cycle, cpu_rdata);
    end
  endtask

  task automatic test_addr_change();
    mem_model[7] = 64'h77;
    cpu_req = 1; cpu_we = 0; cpu_addr = 10'd5;
    for (int c = 1; c <= 4; c++) begin
      tick();
      if (c <= 2) begin
        total++;
        if (mem_addr !== 10'd5) begin
          bad++; $display("FAIL addr_hold: cycle %0d got %0d want 5", c, mem_addr);
        end
        cpu_addr = 10'd7;
      end
      if (c == 3) begin
        total++;
        if (!cpu_ack || cpu_rdata !== 64'hDEAD) begin
          bad++; $display("FAIL addr_hold_data: ack=%b rdata=%h want 1/dead", cpu_ack, cpu_rdata);
        end
        cpu_req = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_cpu_write();
    test_cpu_read();
    test_arbitration();
    test_ext_back_to_back();
    test_reset_abort();
    test_addr_change();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Two-port arbiter and access sequencer in front of data_ram. It shares the single data memory between the CPU datapath port and an external port (program loader / debug host). It registers each granted transaction and drives data_ram's cs/memRead/memWrite for a fixed number of cycles. It then returns read data and a one-cycle ack to the winning requester. CPU has priority, and an anti-starvation counter guarantees the external port progress.

Parameters:
ADDRESS_BUS_WIDTH, 10, address width of data_ram
DATA_BUS_WIDTH, 64, data word width
ACCESS_CYCLES, 2, cycles mem strobes are held per transaction (legal range 1..15)
STARVE_LIMIT, 4, lost arbitrations after which ext wins the next one (legal range 1..15)

Ports:
clk  input  1  system clock; all state changes on rising edge
reset  input  1  asynchronous, active-low reset
cpu_req  input  1  CPU transaction request (level)
cpu_we  input  1  1 = write, 0 = read
cpu_addr  input  ADDRESS_BUS_WIDTH  CPU address
cpu_wdata  input  DATA_BUS_WIDTH  CPU write data
cpu_rdata  output  DATA_BUS_WIDTH  CPU read data, valid with cpu_ack
cpu_ack  output  1  one-cycle completion pulse to CPU
ext_req  input  1  external request (level)
ext_we  input  1  1 = write, 0 = read
ext_addr  input  ADDRESS_BUS_WIDTH  external address
ext_wdata  input  DATA_BUS_WIDTH  external write data
ext_rdata  output  DATA_BUS_WIDTH  external read data, valid with ext_ack
ext_ack  output  1  one-cycle completion pulse to external port
mem_cs  output  1  data_ram chip select
mem_read  output  1  data_ram memRead
mem_write  output  1  data_ram memWrite
mem_addr  output  ADDRESS_BUS_WIDTH  data_ram address
mem_wdata  output  DATA_BUS_WIDTH  data_ram writeData
mem_rdata  input  DATA_BUS_WIDTH  data_ram readData
busy  output  1  1 whenever state != IDLE
grant_ext  output  1  1 while the current transaction belongs to the ext port

Behaviour:
- Interface: one clock; reset is asynchronous and active-low. The clock port is clk and the reset port is reset.
- Reset (reset=0, takes effect immediately): state=IDLE, cycle counter=0, starve_cnt=0. All outputs are 0, including cpu_rdata, ext_rdata and the mem_* buses.
- FSM states and transitions:
  - IDLE:
    - Arbitrate on each rising edge if cpu_req or ext_req is high.
    - The winner's we/addr/wdata are latched into transaction registers, the owner is recorded, and the FSM goes to ACCESS with counter=0.
  - ACCESS:
    - mem_cs=1, mem_read=~we, mem_write=we; mem_addr/mem_wdata come from the latched registers.
    - counter increments each cycle. When counter==ACCESS_CYCLES-1 the FSM goes to DONE.
    - On that same edge, a read captures mem_rdata into the owner's rdata register.
  - DONE:
    - The owner's ack=1 for exactly this cycle; mem_* return to 0.
    - The FSM goes to IDLE next edge.
- Arbitration rule:
  - Only one request present: that port wins.
  - Both present: ext wins if starve_cnt>=STARVE_LIMIT; otherwise CPU wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each IDLE arbitration where ext_req=1 but CPU wins.
  - Clears to 0 when ext is granted or when ext_req=0 during IDLE.
- Handshake:
  - A requester holds req/we/addr/wdata stable from assertion until its ack.
  - Inputs are sampled only in IDLE, so changes during ACCESS/DONE have no effect on the current transaction.
  - req still high in the cycle after ack is a new transaction, arbitrated normally.
- Latency: request first seen in IDLE at edge N gives ack high in the cycle after edge N+ACCESS_CYCLES. Default: ack is 3 cycles after req rises, and mem strobes are high for exactly 2 cycles.
- Throughput: one transaction per ACCESS_CYCLES+2 cycles. A continuously requesting single port gets back-to-back transactions with one IDLE cycle between them.
- rdata registers:
  - Each port's rdata holds its value until that port's next completed read.
  - A write transaction leaves both rdata registers unchanged.
  - The other port's rdata never changes.
- ack exclusivity: cpu_ack and ext_ack are never high simultaneously, and at most one ack is issued per transaction.
- Reset mid-ACCESS/DONE aborts the transaction: no ack is issued, and mem strobes drop asynchronously. A partially strobed write is accepted as undefined memory content.
- Addresses pass through unchecked. Range policing (e.g. the instruction region at 512+) belongs to the requesters.

Test Plan:
- Reset, then cpu_req=1, cpu_we=1, cpu_addr=10'd5, cpu_wdata=64'hDEAD -> mem_write=1 and mem_addr=5 for exactly 2 cycles, cpu_ack pulses 3 cycles after req, ext_ack stays 0.
- CPU read of addr 5 with mem_rdata model returning 64'hDEAD -> cpu_rdata=64'hDEAD coincident with cpu_ack; ext_rdata stays 0.
- cpu_req and ext_req both held high continuously -> grant order CPU x4, EXT x1, CPU x4, EXT x1; starve_cnt never exceeds 4.
- ext_req alone, ext read addr 10'd300 -> grant_ext=1 during ACCESS, ext_ack after 3 cycles, then back-to-back repeat with a 1-cycle IDLE gap.
- Assert reset=0 in the 2nd ACCESS cycle -> mem_cs/mem_read/mem_write drop immediately, no ack, and busy=0. After release, a new request completes normally.
- During ACCESS, change cpu_addr from 5 to 7 -> mem_addr stays 5 for the whole transaction.
